// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
package spi_bridge_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_FETCH,
    DATA,
    WR_ISSUE
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                  input logic inc);
    return a + {{(ADDR_W-1){1'b0}}, inc};
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall detection
// taken from the last two synchronized samples.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns command/data frames into one-clock read and
// write strobes on the register-block bus. All logic runs on clk.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (sclk),
    .o_sync(w_sclk_sync),
    .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (cs_n),
    .o_sync(w_cs_sync),
    .o_rise(w_cs_rise),
    .o_fall(w_cs_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-2:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_data_write;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_miso_oe;
  logic [DATA_W-1:0] w_rx_byte;
  logic              w_last_bit;
  logic              w_start;
  logic              w_inc;

  // The byte completing on this rise includes the mosi bit being sampled now.
  assign w_rx_byte  = {r_rx_shift, w_mosi};
  assign w_last_bit = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_start    = w_cs_fall && !w_sclk_sync;
  assign w_inc      = (AUTO_INC != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_start) w_state_nxt = CMD;
      CMD: begin
        if (w_cs_sync)       w_state_nxt = IDLE;
        else if (w_last_bit) w_state_nxt = w_rx_byte[CMD_RW_BIT] ? DATA : RD_FETCH;
      end
      RD_FETCH: w_state_nxt = w_cs_sync ? IDLE : DATA;
      DATA: begin
        if (w_cs_sync)       w_state_nxt = IDLE;
        else if (w_last_bit) w_state_nxt = r_rw ? WR_ISSUE : RD_FETCH;
      end
      WR_ISSUE: w_state_nxt = DATA;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_data_write <= '0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: r_bit_cnt <= '0;
        CMD: begin
          if (!w_cs_sync && w_sclk_rise) begin
            r_rx_shift <= w_rx_byte[DATA_W-2:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_rw   <= w_rx_byte[CMD_RW_BIT];
              r_addr <= w_rx_byte[ADDR_W-1:0];
            end
          end
        end
        RD_FETCH: r_tx_shift <= data_read;
        DATA: begin
          if (!w_cs_sync && w_sclk_rise) begin
            r_rx_shift <= w_rx_byte[DATA_W-2:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              if (r_rw) r_data_write <= w_rx_byte;
              else      r_addr       <= addr_step(r_addr, w_inc);
            end
          end
          // The fall right after a byte load (bit_cnt==0) must keep bit7 in place.
          if (!w_cs_sync && w_sclk_fall && (r_bit_cnt != 3'd0))
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
        WR_ISSUE: r_addr <= addr_step(r_addr, w_inc);
        default:  r_bit_cnt <= '0;
      endcase
      if (w_cs_sync && (r_state != WR_ISSUE)) r_bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_miso_oe <= 1'b0;
    else if (w_cs_fall) r_miso_oe <= 1'b1;
    else if (w_cs_rise) r_miso_oe <= 1'b0;
  end

  assign read       = (r_state == RD_FETCH);
  assign write      = (r_state == WR_ISSUE);
  assign addr       = r_addr;
  assign data_write = r_data_write;
  assign miso_oe    = r_miso_oe;
  assign miso       = (r_state == DATA && !r_rw) ? r_tx_shift[DATA_W-1] : 1'b0;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench: a mode-0 SPI master drives two bridges (AUTO_INC=1 and 0)
// and bus activity is logged and compared against hand-computed values.
module tb_spi_reg_bridge;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs0_n = 1'b1;
  logic       cs1_n = 1'b1;
  logic       miso0, miso_oe0, read0, write0;
  logic       miso1, miso_oe1, read1, write1;
  logic [5:0] addr0, addr1;
  logic [7:0] dw0, dw1, dr0, dr1;

  int total = 0;
  int bad   = 0;

  logic [5:0] wa0[$], wa1[$], ra0[$], ra1[$];
  logic [7:0] wd0[$], wd1[$];
  logic       both_seen = 1'b0;

  always #5 clk = ~clk;

  assign dr0 = read0 ? ({2'b00, addr0} ^ 8'hCE) : 8'h00;
  assign dr1 = read1 ? 8'h5A : 8'h00;

  spi_reg_bridge #(.SYNC_STAGES(2), .AUTO_INC(1)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs0_n), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .read(read0), .write(write0),
    .addr(addr0), .data_write(dw0), .data_read(dr0)
  );

  spi_reg_bridge #(.SYNC_STAGES(2), .AUTO_INC(0)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs1_n), .mosi(mosi),
    .miso(miso1), .miso_oe(miso_oe1), .read(read1), .write(write1),
    .addr(addr1), .data_write(dw1), .data_read(dr1)
  );

  always @(negedge clk) begin
    if (write0) begin wa0.push_back(addr0); wd0.push_back(dw0); end
    if (read0)  ra0.push_back(addr0);
    if (write1) begin wa1.push_back(addr1); wd1.push_back(dw1); end
    if (read1)  ra1.push_back(addr1);
    if ((read0 && write0) || (read1 && write1)) both_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); ra0.delete();
    wa1.delete(); wd1.delete(); ra1.delete();
  endtask

  task automatic spi_xfer(input bit sel, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #HALF;
      rx[7-i] = sel ? miso1 : miso0;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input bit sel, input logic [31:0] bytes, input int n,
                       output logic [31:0] rxw);
    logic [7:0] b;
    rxw = '0;
    if (sel) cs1_n = 1'b0; else cs0_n = 1'b0;
    #HALF;
    for (int k = 0; k < n; k++) begin
      spi_xfer(sel, bytes[31-8*k -: 8], 8, b);
      rxw[31-8*k -: 8] = b;
    end
    #HALF;
    cs0_n = 1'b1;
    cs1_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    total++;
    if ({read0, write0, addr0, dw0, miso0, miso_oe0} !== 18'h0) begin
      bad++;
      $display("FAIL reset0: got r=%b w=%b a=%h d=%h miso=%b oe=%b want all 0",
               read0, write0, addr0, dw0, miso0, miso_oe0);
    end
    total++;
    if ({read1, write1, addr1, dw1, miso1, miso_oe1} !== 18'h0) begin
      bad++;
      $display("FAIL reset1: got r=%b w=%b a=%h d=%h miso=%b oe=%b want all 0",
               read1, write1, addr1, dw1, miso1, miso_oe1);
    end
    rst = 1'b0;
    #50;
  endtask

  task automatic test_single_write();
    logic [7:0] b0, b1;
    clear_logs();
    cs0_n = 1'b0;
    #HALF;
    total++;
    if (miso_oe0 !== 1'b1) begin
      bad++; $display("FAIL oe_in_frame: got %b want 1", miso_oe0);
    end
    spi_xfer(1'b0, 8'h8A, 8, b0);
    spi_xfer(1'b0, 8'h35, 8, b1);
    #HALF;
    cs0_n = 1'b1;
    #200;
    total++;
    if (miso_oe0 !== 1'b0) begin
      bad++; $display("FAIL oe_after_frame: got %b want 0", miso_oe0);
    end
    total++;
    if (wa0.size() !== 1) begin
      bad++; $display("FAIL wr_count: got %0d want 1", wa0.size());
    end
    total++;
    if ((wa0.size() > 0 ? wa0[0] : 6'hxx) !== 6'h0A || (wd0.size() > 0 ? wd0[0] : 8'hxx) !== 8'h35) begin
      bad++; $display("FAIL wr_single: got a=%h d=%h want a=0a d=35",
                      wa0.size() > 0 ? wa0[0] : 6'hxx, wd0.size() > 0 ? wd0[0] : 8'hxx);
    end
    total++;
    if (ra0.size() !== 0) begin
      bad++; $display("FAIL wr_no_read: got %0d reads want 0", ra0.size());
    end
    total++;
    if ({b0, b1} !== 16'h0000) begin
      bad++; $display("FAIL wr_miso_quiet: got %h want 0000", {b0, b1});
    end
  endtask

  task automatic test_single_read();
    logic [31:0] rxw;
    clear_logs();
    frame(1'b0, 32'h0D00_0000, 2, rxw);
    total++;
    if (ra0.size() !== 2) begin
      bad++; $display("FAIL rd_count: got %0d want 2", ra0.size());
    end
    total++;
    if ((ra0.size() > 0 ? ra0[0] : 6'hxx) !== 6'h0D) begin
      bad++; $display("FAIL rd_addr: got %h want 0d", ra0.size() > 0 ? ra0[0] : 6'hxx);
    end
    total++;
    if ((ra0.size() > 1 ? ra0[1] : 6'hxx) !== 6'h0E) begin
      bad++; $display("FAIL rd_prefetch: got %h want 0e", ra0.size() > 1 ? ra0[1] : 6'hxx);
    end
    total++;
    if (rxw[31:16] !== 16'h00C3) begin
      bad++; $display("FAIL rd_miso: got %h want 00c3", rxw[31:16]);
    end
    total++;
    if (wa0.size() !== 0) begin
      bad++; $display("FAIL rd_no_write: got %0d writes want 0", wa0.size());
    end
  endtask

  task automatic test_burst_write();
    logic [31:0] rxw;
    logic [5:0]  ea [3];
    logic [7:0]  ed [3];
    ea = '{6'h00, 6'h01, 6'h02};
    ed = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    frame(1'b0, 32'h8011_2233, 4, rxw);
    total++;
    if (wa0.size() !== 3) begin
      bad++; $display("FAIL bw_count: got %0d want 3", wa0.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ((wa0.size() > i ? wa0[i] : 6'hxx) !== ea[i] || (wd0.size() > i ? wd0[i] : 8'hxx) !== ed[i]) begin
        bad++; $display("FAIL bw_%0d: got a=%h d=%h want a=%h d=%h", i,
                        wa0.size() > i ? wa0[i] : 6'hxx, wd0.size() > i ? wd0[i] : 8'hxx, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_burst_read_wrap();
    logic [31:0] rxw;
    logic [5:0]  ea [3];
    ea = '{6'h3E, 6'h3F, 6'h00};
    clear_logs();
    frame(1'b0, 32'h3E00_0000, 3, rxw);
    total++;
    if (ra0.size() !== 3) begin
      bad++; $display("FAIL br_count: got %0d want 3", ra0.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ((ra0.size() > i ? ra0[i] : 6'hxx) !== ea[i]) begin
        bad++; $display("FAIL br_addr_%0d: got %h want %h", i, ra0.size() > i ? ra0[i] : 6'hxx, ea[i]);
      end
    end
    total++;
    if (rxw[23:8] !== 16'hF0F1) begin
      bad++; $display("FAIL br_miso: got %h want f0f1", rxw[23:8]);
    end
  endtask

  task automatic test_abort();
    logic [7:0]  b;
    logic [31:0] rxw;
    clear_logs();
    cs0_n = 1'b0;
    #HALF;
    spi_xfer(1'b0, 8'h82, 8, b);
    spi_xfer(1'b0, 8'hFF, 5, b);
    #HALF;
    cs0_n = 1'b1;
    #200;
    total++;
    if (wa0.size() !== 0) begin
      bad++; $display("FAIL abort_no_write: got %0d writes want 0", wa0.size());
    end
    total++;
    if (miso_oe0 !== 1'b0) begin
      bad++; $display("FAIL abort_oe: got %b want 0", miso_oe0);
    end
    frame(1'b0, 32'h817F_0000, 2, rxw);
    total++;
    if (wa0.size() !== 1 || (wa0.size() > 0 ? wa0[0] : 6'hxx) !== 6'h01 || (wd0.size() > 0 ? wd0[0] : 8'hxx) !== 8'h7F) begin
      bad++; $display("FAIL abort_next: got n=%0d a=%h d=%h want n=1 a=01 d=7f", wa0.size(),
                      wa0.size() > 0 ? wa0[0] : 6'hxx, wd0.size() > 0 ? wd0[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  b;
    logic [31:0] rxw;
    clear_logs();
    cs0_n = 1'b0;
    #HALF;
    spi_xfer(1'b0, 8'h85, 4, b);
    #7;
    rst = 1'b1;
    #1;
    total++;
    if ({read0, write0, addr0, dw0, miso0, miso_oe0} !== 18'h0) begin
      bad++;
      $display("FAIL midreset: got r=%b w=%b a=%h d=%h miso=%b oe=%b want all 0",
               read0, write0, addr0, dw0, miso0, miso_oe0);
    end
    #30;
    rst = 1'b0;
    #40;
    spi_xfer(1'b0, 8'h85, 8, b);
    spi_xfer(1'b0, 8'h5A, 8, b);
    #HALF;
    cs0_n = 1'b1;
    #200;
    total++;
    if (wa0.size() !== 0 || ra0.size() !== 0) begin
      bad++; $display("FAIL midreset_no_resync: got w=%0d r=%0d want 0 0", wa0.size(), ra0.size());
    end
    frame(1'b0, 32'h855A_0000, 2, rxw);
    total++;
    if (wa0.size() !== 1 || (wa0.size() > 0 ? wa0[0] : 6'hxx) !== 6'h05 || (wd0.size() > 0 ? wd0[0] : 8'hxx) !== 8'h5A) begin
      bad++; $display("FAIL midreset_next: got n=%0d a=%h d=%h want n=1 a=05 d=5a", wa0.size(),
                      wa0.size() > 0 ? wa0[0] : 6'hxx, wd0.size() > 0 ? wd0[0] : 8'hxx);
    end
  endtask

  task automatic test_no_inc();
    logic [31:0] rxw;
    clear_logs();
    frame(1'b1, 32'h8701_0100, 3, rxw);
    total++;
    if (wa1.size() !== 2) begin
      bad++; $display("FAIL ni_count: got %0d want 2", wa1.size());
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if ((wa1.size() > i ? wa1[i] : 6'hxx) !== 6'h07 || (wd1.size() > i ? wd1[i] : 8'hxx) !== 8'h01) begin
        bad++; $display("FAIL ni_%0d: got a=%h d=%h want a=07 d=01", i,
                        wa1.size() > i ? wa1[i] : 6'hxx, wd1.size() > i ? wd1[i] : 8'hxx);
      end
    end
    total++;
    if (wa0.size() !== 0) begin
      bad++; $display("FAIL ni_other_idle: got %0d writes want 0", wa0.size());
    end
  endtask

  task automatic test_strobe_exclusive();
    total++;
    if (both_seen !== 1'b0) begin
      bad++; $display("FAIL strobe_overlap: got %b want 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_burst_read_wrap();
    test_abort();
    test_reset_midframe();
    test_no_inc();
    test_strobe_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
